mem_word_port: RTL and testbench

- Initiator side of the byte-wide memory bus (addr / read_en / write_en / ready) used by the memory and ROM responders.
- Takes one 8-, 16- or 32-bit load or store request from the core.
- Performs it as a sequence of byte transactions, little-endian, and returns one response.
- Sits between the cpu datapath and the memory responder; replaces ad-hoc byte sequencing in the core.

---
 rtl/mem_bus_pkg.sv | 53 +++++
 rtl/mem_word_port.sv | 194 +++++++++++++++++++
 tb/tb_mem_word_port.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the byte-wide memory bus initiator.
//
// Contents:
//   SZ_BYTE / SZ_HALF / SZ_WORD / SZ_INVALID : request size encodings
//   state_t                                  : mem_word_port FSM states
//   DEFAULT_TIMEOUT                          : cycles to wait for mem_ready per read byte
//   last_index()                             : index of the final byte for a size
//   extend_load()                            : zero/sign extension of an assembled load
package mem_bus_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'd0;
  localparam logic [1:0] SZ_HALF    = 2'd1;
  localparam logic [1:0] SZ_WORD    = 2'd2;
  localparam logic [1:0] SZ_INVALID = 2'd3;

  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Index of the last byte lane touched by a request of the given size.
  // The invalid encoding never reaches the bus, so its value is irrelevant.
  function automatic logic [1:0] last_index(input logic [1:0] size);
    logic [1:0] idx;
    idx = 2'd3;
    case (size)
      SZ_BYTE: idx = 2'd0;
      SZ_HALF: idx = 2'd1;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Widens the assembled little-endian load value to 32 bits, either
  // zero-filling or replicating the top bit of the most significant byte read.
  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  size,
                                              input logic        is_signed);
    logic [31:0] result;
    result = raw;
    case (size)
      SZ_BYTE: result = {{24{is_signed & raw[7]}}, raw[7:0]};
      SZ_HALF: result = {{16{is_signed & raw[15]}}, raw[15:0]};
      default: result = raw;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mem_word_port.sv
// Initiator side of the byte-wide memory bus.
//
// Accepts one 8/16/32-bit load or store from the core and carries it out as a
// little-endian sequence of single-byte bus transactions, then returns a single
// one-cycle response.
//
// Ports:
//   clk, rst_n            clock (posedge) and synchronous active-low reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_write             1 = store, 0 = load
//   req_size              0 byte, 1 half, 2 word, 3 invalid (error response)
//   req_signed            sign-extend narrow loads
//   req_addr              address of least significant byte
//   req_wdata             store data, low bytes used
//   resp_valid            one-cycle completion pulse
//   resp_rdata            extended load result (0 for stores and errors)
//   resp_err              timeout or invalid size, qualified by resp_valid
//   mem_addr              bus byte address
//   mem_data_in           byte sent to the responder on a write
//   mem_data_out          byte returned by the responder
//   memory_read_en        read strobe
//   memory_write_en       write strobe
//   mem_ready             one-cycle pulse marking mem_data_out valid
module mem_word_port
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data_in,
  input  logic [7:0]        mem_data_out,
  output logic              memory_read_en,
  output logic              memory_write_en,
  input  logic              mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t state;
  state_t next_state;

  logic [ADDR_W-1:0] base_addr;
  logic [31:0]       store_data;
  logic [31:0]       load_data;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              is_load;
  logic              err_q;
  logic [1:0]        idx;
  logic [1:0]        last_idx;
  logic [CNT_W-1:0]  wait_cnt;

  logic              last_byte;
  logic              timed_out;

  assign last_byte = (idx == last_idx);
  assign timed_out = !mem_ready && (wait_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection and all bus/response outputs. The strobes depend
  // only on the state, so read and write can never be high together.
  always_comb begin
    next_state      = state;
    req_ready       = 1'b0;
    memory_read_en  = 1'b0;
    memory_write_en = 1'b0;
    mem_addr        = '0;
    mem_data_in     = 8'h00;
    resp_valid      = 1'b0;
    resp_err        = 1'b0;
    resp_rdata      = 32'h0;

    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_size == SZ_INVALID) begin
            next_state = ST_RESP;
          end else if (req_write) begin
            next_state = ST_WR;
          end else begin
            next_state = ST_RD;
          end
        end
      end

      ST_RD: begin
        memory_read_en = 1'b1;
        mem_addr       = base_addr + ADDR_W'(idx);
        if ((mem_ready && last_byte) || timed_out) begin
          next_state = ST_RESP;
        end
      end

      ST_WR: begin
        memory_write_en = 1'b1;
        mem_addr        = base_addr + ADDR_W'(idx);
        mem_data_in     = store_data[{idx, 3'b000} +: 8];
        if (last_byte) begin
          next_state = ST_RESP;
        end
      end

      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (is_load && !err_q) begin
          resp_rdata = extend_load(load_data, size_q, signed_q);
        end
        next_state = ST_IDLE;
      end

      default: next_state = ST_IDLE;
    endcase
  end

  // Request latch, byte-lane assembly and per-byte timeout counter.
  // The wait counter restarts on every captured byte so TIMEOUT bounds the
  // wait for each individual byte, not the whole request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_addr  <= '0;
      store_data <= 32'h0;
      load_data  <= 32'h0;
      size_q     <= SZ_BYTE;
      signed_q   <= 1'b0;
      is_load    <= 1'b0;
      err_q      <= 1'b0;
      idx        <= 2'd0;
      last_idx   <= 2'd0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            base_addr  <= req_addr;
            store_data <= req_wdata;
            load_data  <= 32'h0;
            size_q     <= req_size;
            signed_q   <= req_signed;
            is_load    <= !req_write;
            err_q      <= (req_size == SZ_INVALID);
            idx        <= 2'd0;
            last_idx   <= last_index(req_size);
            wait_cnt   <= '0;
          end
        end

        ST_RD: begin
          if (mem_ready) begin
            load_data[{idx, 3'b000} +: 8] <= mem_data_out;
            idx      <= idx + 2'd1;
            wait_cnt <= '0;
          end else if (timed_out) begin
            err_q     <= 1'b1;
            load_data <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_WR: begin
          idx <= idx + 2'd1;
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_word_port.sv
// Directed self-checking bench for mem_word_port with a small byte memory
// responder that raises mem_ready one edge after sampling a read, and that
// ignores a repeated read of the address it served last.
module tb_mem_word_port;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in;
  logic [7:0]  mem_data_out;
  logic        memory_read_en;
  logic        memory_write_en;
  logic        mem_ready;

  mem_word_port #(.TIMEOUT(16), .ADDR_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .mem_addr        (mem_addr),
    .mem_data_in     (mem_data_in),
    .mem_data_out    (mem_data_out),
    .memory_read_en  (memory_read_en),
    .memory_write_en (memory_write_en),
    .mem_ready       (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Responder state and activity logs.
  logic [7:0]  mem [0:511];
  logic        rsp_on = 1'b1;
  logic        have_last = 1'b0;
  logic [31:0] last_addr = 32'h0;
  logic [31:0] served_q[$];
  logic [31:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  int          wr_cyc_q[$];
  int          rd_cycles;
  int          both_cycles;
  logic [31:0] got_rdata;
  logic        got_err;

  // Byte memory responder: serves a read one edge after sampling it.
  always @(posedge clk) begin
    mem_ready <= 1'b0;
    if (!memory_read_en) begin
      have_last <= 1'b0;
    end else if (rsp_on && !(have_last && mem_addr == last_addr)) begin
      mem_ready    <= 1'b1;
      mem_data_out <= mem[mem_addr[8:0]];
      last_addr    <= mem_addr;
      have_last    <= 1'b1;
      served_q.push_back(mem_addr);
    end
    if (memory_write_en) begin
      mem[mem_addr[8:0]] <= mem_data_in;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Presents one request for a single accepting edge.
  task automatic applyStimulus(input logic write, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr,
                               input logic [31:0] wdata);
    served_q.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    rd_cycles   = 0;
    both_cycles = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = write;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Counts negedges after acceptance until resp_valid, logging bus activity.
  task automatic waitResp(output int lat);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      lat = c;
      if (memory_read_en) rd_cycles++;
      if (memory_read_en && memory_write_en) both_cycles++;
      if (memory_write_en) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_data_in);
        wr_cyc_q.push_back(c);
      end
      if (resp_valid) begin
        got_rdata = resp_rdata;
        got_err   = resp_err;
        return;
      end
    end
    lat = 99;
    got_rdata = 32'hXXXXXXXX;
    got_err   = 1'bx;
  endtask

  int lat;
  int pulses;

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[9'h010] = 8'h78; mem[9'h011] = 8'h56;
    mem[9'h012] = 8'h34; mem[9'h013] = 8'h12;
    mem[9'h020] = 8'h80; mem[9'h021] = 8'hFF;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_data_out = 8'h00; mem_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_read_en", 32'(memory_read_en), 32'd0);
    checkOutput("reset_write_en", 32'(memory_write_en), 32'd0);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_resp_err", 32'(resp_err), 32'd0);
    checkOutput("reset_rdata", resp_rdata, 32'h0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkOutput("reset_data_in", 32'(mem_data_in), 32'h0);
    rst_n = 1'b1;

    // Word load: 8 posedges of bus activity, response in the 9th cycle.
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    waitResp(lat);
    checkOutput("wload_latency", 32'(lat), 32'd9);
    checkOutput("wload_rdata", got_rdata, 32'h12345678);
    checkOutput("wload_err", 32'(got_err), 32'd0);
    checkOutput("wload_nserved", 32'(served_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < served_q.size(); i++)
      checkOutput($sformatf("wload_addr%0d", i), served_q[i], 32'h10 + 32'(i));
    @(negedge clk);
    checkOutput("wload_ready_after", 32'(req_ready), 32'd1);
    checkOutput("wload_valid_once", 32'(resp_valid), 32'd0);

    // Half loads, signed then unsigned.
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
    waitResp(lat);
    checkOutput("shalf_rdata", got_rdata, 32'hFFFFFF80);
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h20, 32'h0);
    waitResp(lat);
    checkOutput("uhalf_rdata", got_rdata, 32'h0000FF80);
    checkOutput("uhalf_latency", 32'(lat), 32'd5);

    // Word store crossing 0x100.
    applyStimulus(1'b1, 2'd2, 1'b0, 32'hFE, 32'hDEADBEEF);
    waitResp(lat);
    checkOutput("wstore_latency", 32'(lat), 32'd5);
    checkOutput("wstore_rdata", got_rdata, 32'h0);
    checkOutput("wstore_err", 32'(got_err), 32'd0);
    checkOutput("wstore_read_cycles", 32'(rd_cycles), 32'd0);
    checkOutput("wstore_nwrites", 32'(wr_addr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      checkOutput($sformatf("wstore_addr%0d", i), wr_addr_q[i], 32'hFE + 32'(i));
      checkOutput($sformatf("wstore_cyc%0d", i), 32'(wr_cyc_q[i]), 32'(i + 1));
    end
    if (wr_data_q.size() == 4) begin
      checkOutput("wstore_data", {wr_data_q[3], wr_data_q[2], wr_data_q[1], wr_data_q[0]},
                  32'hDEADBEEF);
    end
    applyStimulus(1'b0, 2'd2, 1'b0, 32'hFE, 32'h0);
    waitResp(lat);
    checkOutput("readback_rdata", got_rdata, 32'hDEADBEEF);
    checkOutput("strobes_exclusive", 32'(both_cycles), 32'd0);

    // Half store at the top of the address space wraps to 0.
    applyStimulus(1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h1234A55A);
    waitResp(lat);
    checkOutput("wrap_latency", 32'(lat), 32'd3);
    if (wr_addr_q.size() == 2) begin
      checkOutput("wrap_addr0", wr_addr_q[0], 32'hFFFFFFFF);
      checkOutput("wrap_addr1", wr_addr_q[1], 32'h0);
      checkOutput("wrap_data", {16'h0, wr_data_q[1], wr_data_q[0]}, 32'h0000A55A);
    end else begin
      checkOutput("wrap_nwrites", 32'(wr_addr_q.size()), 32'd2);
    end

    // Silent responder: timeout after 16 read cycles.
    rsp_on = 1'b0;
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h30, 32'h0);
    waitResp(lat);
    checkOutput("tmo_read_cycles", 32'(rd_cycles), 32'd16);
    checkOutput("tmo_latency", 32'(lat), 32'd17);
    checkOutput("tmo_err", 32'(got_err), 32'd1);
    checkOutput("tmo_rdata", got_rdata, 32'h0);
    @(negedge clk);
    checkOutput("tmo_ready_after", 32'(req_ready), 32'd1);
    rsp_on = 1'b1;

    // Invalid size: immediate error response, no bus activity.
    applyStimulus(1'b0, 2'd3, 1'b0, 32'h40, 32'h0);
    waitResp(lat);
    checkOutput("inv_latency", 32'(lat), 32'd1);
    checkOutput("inv_err", 32'(got_err), 32'd1);
    checkOutput("inv_rdata", got_rdata, 32'h0);
    checkOutput("inv_strobes", 32'(rd_cycles + wr_addr_q.size()), 32'd0);

    // Reset while byte 2 of a word load is on the bus.
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    lat = 99;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (memory_read_en && mem_addr == 32'h12) begin
        lat = c;
        break;
      end
    end
    checkOutput("rst_reach_byte2", 32'(lat < 99), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_read_en", 32'(memory_read_en), 32'd0);
    checkOutput("rst_write_en", 32'(memory_write_en), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (resp_valid) pulses++;
      @(negedge clk);
    end
    checkOutput("rst_no_resp", 32'(pulses), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
